// File: rtl/display_pkg.sv
// Shared display types and default raster constants.
// Modules with a non-default BLOCK_DIM build their own group type from rgb_pixel.
package display_pkg;

   localparam int unsigned DEFAULT_BLOCK_DIM = 8;
   localparam int unsigned DEFAULT_H_RES     = 640;
   localparam int unsigned DEFAULT_V_RES     = 480;

   typedef logic [23:0] rgb_pixel;
   typedef rgb_pixel [DEFAULT_BLOCK_DIM-1:0] pixel_group;

endpackage

// File: rtl/pixel_group_fifo.sv
// Group-wide FIFO: storage, pointers and occupancy count, with synchronous flush.
module pixel_group_fifo #(
   parameter int unsigned WIDTH = 192,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push & ~full & ~flush;
   assign pop_ok  = pop & ~empty & ~flush;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/disp_stream_out.sv
// Pixel-group FIFO to AXI4-Stream video serialiser with tuser/tlast generation.
// Optional DISP_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module disp_stream_out
   import display_pkg::*;
#(
   parameter int unsigned BLOCK_DIM  = DEFAULT_BLOCK_DIM,
   parameter int unsigned H_RES      = DEFAULT_H_RES,
   parameter int unsigned V_RES      = DEFAULT_V_RES,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_valid_in,
   input  logic [24*BLOCK_DIM-1:0] rgb_in,
   input  logic                    reset_frame,
   output logic                    vdma_ready,
   output logic [23:0]             m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tuser,
   output logic                    m_axis_tlast
`ifdef DISP_UNDERRUN_CNT_EN
   ,
   output logic [15:0]             underrun_count
`endif
);

   localparam int unsigned SW = (BLOCK_DIM > 1) ? $clog2(BLOCK_DIM) : 1;
   localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   typedef rgb_pixel [BLOCK_DIM-1:0] group_t;

   group_t        head;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          beat;
   logic          last_sub;
   logic [SW-1:0] sub_idx;
   logic [XW-1:0] x;
   logic [YW-1:0] y;

   pixel_group_fifo #(
      .WIDTH (24*BLOCK_DIM),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (reset_frame),
      .push  (push),
      .wdata (rgb_in),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // Ready comes only from registered occupancy, so a pop never reopens it early.
   assign vdma_ready    = (count < CW'(FIFO_DEPTH));
   assign push          = disp_valid_in & ~full;
   assign m_axis_tvalid = ~empty;
   assign m_axis_tdata  = empty ? '0 : head[sub_idx];
   assign beat          = m_axis_tvalid & m_axis_tready;
   assign last_sub      = (sub_idx == SW'(BLOCK_DIM-1));
   assign pop           = beat & last_sub;
   assign m_axis_tuser  = m_axis_tvalid & (x == '0) & (y == '0);
   assign m_axis_tlast  = m_axis_tvalid & (x == XW'(H_RES-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sub_idx <= '0;
         x       <= '0;
         y       <= '0;
      end else if (reset_frame) begin
         sub_idx <= '0;
         x       <= '0;
         y       <= '0;
      end else if (beat) begin
         sub_idx <= last_sub ? '0 : sub_idx + 1'b1;
         if (x == XW'(H_RES-1)) begin
            x <= '0;
            y <= (y == YW'(V_RES-1)) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

`ifdef DISP_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_count <= '0;
      end else if (reset_frame) begin
         underrun_count <= '0;
      end else if (m_axis_tready && empty && ((x != '0) || (y != '0))
                   && (underrun_count != '1)) begin
         underrun_count <= underrun_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_disp_stream_out.sv
// Directed bench for disp_stream_out (BLOCK_DIM=8, H_RES=16, V_RES=2, FIFO_DEPTH=4).
// Underrun counter checks are compiled only with DISP_UNDERRUN_CNT_EN.
module tb_disp_stream_out;

   localparam int BD = 8;
   localparam int HR = 16;
   localparam int VR = 2;
   localparam int FD = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              disp_valid_in;
   logic [24*BD-1:0]  rgb_in;
   logic              reset_frame;
   logic              vdma_ready;
   logic [23:0]       m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tuser;
   logic              m_axis_tlast;
`ifdef DISP_UNDERRUN_CNT_EN
   logic [15:0]       underrun_count;
`endif

   int total = 0;
   int bad   = 0;
   int unsigned cyc = 0;

   typedef struct {
      logic [23:0] d;
      logic        u;
      logic        l;
      int unsigned c;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;

   disp_stream_out #(
      .BLOCK_DIM  (BD),
      .H_RES      (HR),
      .V_RES      (VR),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .disp_valid_in  (disp_valid_in),
      .rgb_in         (rgb_in),
      .reset_frame    (reset_frame),
      .vdma_ready     (vdma_ready),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tuser   (m_axis_tuser),
      .m_axis_tlast   (m_axis_tlast)
`ifdef DISP_UNDERRUN_CNT_EN
      ,
      .underrun_count (underrun_count)
`endif
   );

   always @(posedge clk) cyc <= cyc + 1;

   // A handshake seen mid-cycle completes at the next rising edge unless the frame is reset.
   always @(negedge clk) begin
      if (rst_n && m_axis_tvalid && m_axis_tready && !reset_frame)
         q.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast, c: cyc});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [24*BD-1:0] grp(input logic [23:0] base);
      logic [24*BD-1:0] g;
      for (int i = 0; i < BD; i++) g[24*i +: 24] = base + 24'(i + 1);
      return g;
   endfunction

   task automatic push_wait(input logic [23:0] base);
      int n = 0;
      while (!vdma_ready && n < 200) begin
         tick();
         n++;
      end
      if (!vdma_ready) check("push ready timeout", 32'(vdma_ready), 32'd1);
      disp_valid_in = 1'b1;
      rgb_in        = grp(base);
      tick();
      disp_valid_in = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int k = 0;
      while (q.size() < n && k < 2000) begin
         tick();
         k++;
      end
      check("beat count", q.size(), n);
   endtask

   task automatic frame_reset();
      reset_frame = 1'b1;
      tick();
      reset_frame = 1'b0;
   endtask

   // Stream of groups with bases base_step*(g+1): pixel k is base + (k%8) + 1.
   task automatic check_stream(input string tn, input int n, input logic [23:0] base_step,
                               input int user_period);
      for (int k = 0; k < n && k < q.size(); k++) begin
         check($sformatf("%s data[%0d]", tn, k), 32'(q[k].d),
               32'(base_step * 24'(k / BD + 1) + 24'(k % BD + 1)));
         check($sformatf("%s tuser[%0d]", tn, k), 32'(q[k].u), 32'((k % user_period) == 0));
         check($sformatf("%s tlast[%0d]", tn, k), 32'(q[k].l), 32'((k % HR) == HR - 1));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gi;
      int it;
      rst_n         = 1'b0;
      disp_valid_in = 1'b0;
      rgb_in        = '0;
      reset_frame   = 1'b0;
      m_axis_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      check("rst vdma_ready", 32'(vdma_ready), 32'd1);
      check("rst tvalid", 32'(m_axis_tvalid), 32'd0);
      check("rst tuser", 32'(m_axis_tuser), 32'd0);
      check("rst tlast", 32'(m_axis_tlast), 32'd0);
      check("rst tdata", 32'(m_axis_tdata), 32'd0);
      rst_n = 1'b1;
      tick();

      // Single group, pixel 0 one cycle after the push edge.
      m_axis_tready = 1'b1;
      disp_valid_in = 1'b1;
      rgb_in        = grp(24'h0);
      tick();
      disp_valid_in = 1'b0;
      for (int k = 0; k < BD; k++) begin
         check($sformatf("t1 tvalid[%0d]", k), 32'(m_axis_tvalid), 32'd1);
         check($sformatf("t1 tdata[%0d]", k), 32'(m_axis_tdata), 32'(k + 1));
         check($sformatf("t1 tuser[%0d]", k), 32'(m_axis_tuser), 32'(k == 0));
         check($sformatf("t1 tlast[%0d]", k), 32'(m_axis_tlast), 32'd0);
         tick();
      end
      check("t1 drained tvalid", 32'(m_axis_tvalid), 32'd0);

`ifdef DISP_UNDERRUN_CNT_EN
      check("ur start", 32'(underrun_count), 32'd0);
      repeat (5) tick();
      check("ur after 5", 32'(underrun_count), 32'd5);
      frame_reset();
      check("ur cleared", 32'(underrun_count), 32'd0);
`endif

      // Fill the FIFO while stalled; a fifth group must be ignored.
      frame_reset();
      m_axis_tready = 1'b0;
      q.delete();
      for (int g = 0; g < FD; g++) push_wait(24'h100 * 24'(g + 1));
      check("t2 ready after 4", 32'(vdma_ready), 32'd0);
      check("t2 head held", 32'(m_axis_tdata), 32'h101);
      disp_valid_in = 1'b1;
      rgb_in        = grp(24'h500);
      tick();
      disp_valid_in = 1'b0;
      check("t2 ready still 0", 32'(vdma_ready), 32'd0);
      m_axis_tready = 1'b1;
      wait_beats(32);
      repeat (4) tick();
      check("t2 no extra beats", q.size(), 32);
      check_stream("t2", 32, 24'h100, 2 * HR);

      // Back-to-back groups across a frame wrap, no idle cycles.
      q.delete();
      for (int g = 0; g < 6; g++) push_wait(24'h1000 * 24'(g + 1));
      wait_beats(48);
      check_stream("t3", 48, 24'h1000, 2 * HR);
      if (q.size() >= 48) check("t3 gap-free", q[47].c - q[0].c, 32'd47);

      // Random backpressure with pushes whenever ready.
      frame_reset();
      q.delete();
      gi = 0;
      it = 0;
      while (q.size() < 64 && it < 3000) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         if (gi < 8 && vdma_ready) begin
            disp_valid_in = 1'b1;
            rgb_in        = grp(24'h10000 * 24'(gi + 1));
            gi++;
         end else begin
            disp_valid_in = 1'b0;
         end
         tick();
         it++;
      end
      disp_valid_in = 1'b0;
      m_axis_tready = 1'b1;
      repeat (4) tick();
      check("t4 beat count", q.size(), 64);
      check_stream("t4", 64, 24'h10000, 2 * HR);

      // reset_frame mid-group with a concurrent push.
      frame_reset();
      q.delete();
      disp_valid_in = 1'b1;
      rgb_in        = grp(24'h700000);
      tick();
      disp_valid_in = 1'b0;
      repeat (3) tick();
      check("t5 sub_idx 3 data", 32'(m_axis_tdata), 32'h700004);
      reset_frame   = 1'b1;
      disp_valid_in = 1'b1;
      rgb_in        = grp(24'h800000);
      tick();
      reset_frame   = 1'b0;
      disp_valid_in = 1'b0;
      check("t5 tvalid after rf", 32'(m_axis_tvalid), 32'd0);
      check("t5 ready after rf", 32'(vdma_ready), 32'd1);
      repeat (3) tick();
      check("t5 push discarded", 32'(m_axis_tvalid), 32'd0);
      check("t5 beats before rf", q.size(), 3);
      push_wait(24'h900000);
      check("t5 restart tvalid", 32'(m_axis_tvalid), 32'd1);
      check("t5 restart tuser", 32'(m_axis_tuser), 32'd1);
      check("t5 restart tdata", 32'(m_axis_tdata), 32'h900001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
